ota_bitstream_decimator: RTL and testbench

- Reader-side companion to the digital OTA/comparator cell. It consumes the 1-bit comparator output stream and turns it into a multi-bit sample.
- Synchronises the asynchronous comparator bit, then counts ones over fixed oversampling windows (accumulate-and-dump).
- Emits one unsigned sample per window over a valid/ready handshake with a 1-entry holding register.
- Sits between the OTA output pin and the digital capture/readout logic.

---
 rtl/ota_decim_pkg.sv | 26 ++
 rtl/ota_decim_sync2.sv | 33 +++
 rtl/ota_bitstream_decimator.sv | 239 +++++++++++++++++++++++
 tb/tb_ota_bitstream_decimator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ota_decim_pkg.sv
// ----------------------------------------------------------------------------
// ota_decim_pkg
// Shared definitions for the OTA bitstream decimator:
//   - state_e      : converter FSM states (IDLE / SETTLE / RUN)
//   - data_w_f()   : output sample width derived from OSR_LOG2
//   - *_MIN/*_MAX  : legal parameter ranges for OSR_LOG2 and SETTLE_WIN
// ----------------------------------------------------------------------------
package ota_decim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam int OSR_LOG2_MIN   = 2;
    localparam int OSR_LOG2_MAX   = 10;
    localparam int SETTLE_WIN_MIN = 0;
    localparam int SETTLE_WIN_MAX = 15;

    // Wide enough for a second-order CIC result of 0..2^(2*osr_log2).
    function automatic int data_w_f(input int osr_log2);
        return 2 * osr_log2 + 1;
    endfunction

endpackage

// File: rtl/ota_decim_sync2.sv
// ----------------------------------------------------------------------------
// ota_decim_sync2
// Two-flop synchroniser for an asynchronous comparator tap.
// Ports:
//   clk      in  sampling clock, rising edge
//   rst      in  asynchronous active-high reset (both flops to 0)
//   async_in in  asynchronous input bit
//   sync_out out synchronised bit, two clocks of latency
// ----------------------------------------------------------------------------
module ota_decim_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; the first stage may go metastable, the second resolves it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/ota_bitstream_decimator.sv
// ----------------------------------------------------------------------------
// ota_bitstream_decimator
// Turns the 1-bit comparator stream of the digital OTA cell into unsigned
// multi-bit samples: synchronise, count ones over 2^OSR_LOG2-clock windows,
// and hand each sample out through a 1-entry valid/ready holding register.
//
// Build option: define OTA_DECIM_SINC2_EN to replace accumulate-and-dump
// with a second-order CIC (the first RUN window is then also discarded).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   bit_in     in   comparator output, asynchronous to clk
//   enable     in   level, 1 = run conversions
//   clear_ovr  in   pulse, clears overrun (a same-cycle set wins)
//   out_data   out  DATA_W  sample value, unsigned, stable while held
//   out_valid  out  sample pending in the holding register
//   out_ready  in   consumer accepts when out_valid && out_ready
//   overrun    out  sticky: a sample was dropped
//   busy       out  converter not IDLE
// ----------------------------------------------------------------------------
module ota_bitstream_decimator
    import ota_decim_pkg::*;
#(
    parameter  int OSR_LOG2   = 6,
    parameter  int SETTLE_WIN = 2,
    localparam int DATA_W     = data_w_f(OSR_LOG2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              enable,
    input  logic              clear_ovr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              busy
);

    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_WIN - 1);
    localparam logic [OSR_LOG2-1:0] CNT_ONE     = {{(OSR_LOG2-1){1'b0}}, 1'b1};

    logic                bit_s;
    state_e              state_r;
    logic [OSR_LOG2-1:0] cnt_w_r;
    logic [3:0]          settle_cnt_r;
    logic                busy_r;
    logic                enable_d_r;
    logic                win_end_s;
    logic                new_sample_s;
    logic [DATA_W-1:0]   sample_s;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic                overrun_r;
    logic                ovr_set_s;
    logic                ovr_clr_s;

    ota_decim_sync2 u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bit_in),
        .sync_out (bit_s)
    );

    // A window completes only if enable is still high on its last cycle
    always_comb begin
        win_end_s = (state_r != IDLE) && enable && (&cnt_w_r);
    end

    // Converter FSM with window and settle counters; busy tracks the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_w_r      <= '0;
            settle_cnt_r <= 4'd0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_w_r      <= '0;
                    settle_cnt_r <= 4'd0;
                    if (enable) begin
                        state_r <= (SETTLE_WIN == 0) ? RUN : SETTLE;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        state_r      <= IDLE;
                        cnt_w_r      <= '0;
                        settle_cnt_r <= 4'd0;
                        busy_r       <= 1'b0;
                    end else begin
                        cnt_w_r <= cnt_w_r + CNT_ONE;
                        busy_r  <= 1'b1;
                        if (win_end_s) begin
                            if (settle_cnt_r == SETTLE_LAST) begin
                                state_r      <= RUN;
                                settle_cnt_r <= 4'd0;
                            end else begin
                                settle_cnt_r <= settle_cnt_r + 4'd1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_r <= IDLE;
                        cnt_w_r <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_w_r <= cnt_w_r + CNT_ONE;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_w_r      <= '0;
                    settle_cnt_r <= 4'd0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

`ifdef OTA_DECIM_SINC2_EN
    logic [DATA_W-1:0] integ1_r;
    logic [DATA_W-1:0] integ2_r;
    logic [DATA_W-1:0] integ1_next_s;
    logic [DATA_W-1:0] integ2_next_s;
    logic [DATA_W-1:0] integ2_dec_r;
    logic [DATA_W-1:0] comb1_r;
    logic [DATA_W-1:0] comb1_s;
    logic [DATA_W-1:0] comb2_s;
    logic              run_primed_r;

    // Integrators include this cycle's bit; combs act on the decimated value
    always_comb begin
        integ1_next_s = integ1_r + {{(DATA_W-1){1'b0}}, bit_s};
        integ2_next_s = integ2_r + integ1_next_s;
        comb1_s       = integ2_next_s - integ2_dec_r;
        comb2_s       = comb1_s - comb1_r;
        sample_s      = comb2_s;
        new_sample_s  = win_end_s && (state_r == RUN) && run_primed_r;
    end

    // CIC state: integrators every active cycle, comb history once per window.
    // run_primed_r holds back the first RUN window until comb history is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ1_r     <= '0;
            integ2_r     <= '0;
            integ2_dec_r <= '0;
            comb1_r      <= '0;
            run_primed_r <= 1'b0;
        end else if ((state_r == IDLE) || !enable) begin
            integ1_r     <= '0;
            integ2_r     <= '0;
            integ2_dec_r <= '0;
            comb1_r      <= '0;
            run_primed_r <= 1'b0;
        end else begin
            integ1_r     <= integ1_next_s;
            integ2_r     <= integ2_next_s;
            run_primed_r <= (state_r == RUN) && (run_primed_r || win_end_s);
            if (win_end_s) begin
                integ2_dec_r <= integ2_next_s;
                comb1_r      <= comb1_s;
            end else begin
                integ2_dec_r <= integ2_dec_r;
                comb1_r      <= comb1_r;
            end
        end
    end
`else
    logic [OSR_LOG2:0] acc_r;
    logic [OSR_LOG2:0] acc_next_s;

    // Ones count including the current cycle, zero-extended to the port width
    always_comb begin
        acc_next_s   = acc_r + {{OSR_LOG2{1'b0}}, bit_s};
        sample_s     = {{(DATA_W-OSR_LOG2-1){1'b0}}, acc_next_s};
        new_sample_s = win_end_s && (state_r == RUN);
    end

    // Accumulate-and-dump: reload to 0 at window end or when stopping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if ((state_r == IDLE) || !enable || win_end_s) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_next_s;
        end
    end
`endif

    // Overrun set/clear decode; enable rising edge also clears
    always_comb begin
        ovr_set_s = new_sample_s && out_valid_r && !out_ready;
        ovr_clr_s = clear_ovr || (enable && !enable_d_r);
    end

    // Holding register: load when empty or draining this cycle, else drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
            enable_d_r  <= 1'b0;
        end else begin
            enable_d_r <= enable;
            if (new_sample_s && (!out_valid_r || out_ready)) begin
                out_data_r  <= sample_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// ----------------------------------------------------------------------------
// tb_ota_bitstream_decimator
// Directed bench for the base (accumulate-and-dump) build with OSR_LOG2=4.
// dut0 uses SETTLE_WIN=0, dut1 uses SETTLE_WIN=2; both share the inputs.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ota_bitstream_decimator;

    localparam int OSR_LOG2 = 4;
    localparam int DATA_W   = 2 * OSR_LOG2 + 1;

    logic clk = 1'b0;
    logic rst;
    logic bit_in;
    logic enable;
    logic clear_ovr;
    logic out_ready;
    logic toggle;
    logic [DATA_W-1:0] data0, data1;
    logic valid0, valid1, ovr0, ovr1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ota_bitstream_decimator #(.OSR_LOG2(OSR_LOG2), .SETTLE_WIN(0)) dut0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .enable(enable),
        .clear_ovr(clear_ovr), .out_data(data0), .out_valid(valid0),
        .out_ready(out_ready), .overrun(ovr0), .busy(busy0)
    );

    ota_bitstream_decimator #(.OSR_LOG2(OSR_LOG2), .SETTLE_WIN(2)) dut1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .enable(enable),
        .clear_ovr(clear_ovr), .out_data(data1), .out_valid(valid1),
        .out_ready(out_ready), .overrun(ovr1), .busy(busy1)
    );

    task automatic tick();
        @(negedge clk);
        if (toggle) bit_in = ~bit_in;
    endtask

    // Advance until dut0 shows out_valid; n = falling edges waited (100 = timeout)
    task automatic wait_valid0(output int n);
        n = 0;
        while (!valid0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic idle_gap();
        enable    = 1'b0;
        out_ready = 1'b1;
        clear_ovr = 1'b0;
        toggle    = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_in = 1'b0; enable = 1'b0; clear_ovr = 1'b0;
        out_ready = 1'b1; toggle = 1'b0;
        repeat (2) tick();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", valid0); end
        checks++; if (data0 !== 9'd0) begin errors++; $display("FAIL reset_data0: got %0d want 0", data0); end
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL reset_ovr0: got %b want 0", ovr0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if ({valid1, ovr1, busy1} !== 3'b000 || data1 !== 9'd0) begin
            errors++; $display("FAIL reset_dut1: got v%b o%b b%b d%0d want all 0", valid1, ovr1, busy1, data1);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_ones();
        int n;
        bit_in = 1'b1; out_ready = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        wait_valid0(n);
        checks++; if (n !== 17) begin errors++; $display("FAIL ones_latency: got %0d edges want 17", n); end
        checks++; if (data0 !== 9'd16) begin errors++; $display("FAIL ones_data1: got %0d want 16", data0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ones_busy: got %b want 1", busy0); end
        tick();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL ones_drain: got %b want 0", valid0); end
        wait_valid0(n);
        checks++; if (n !== 15) begin errors++; $display("FAIL ones_period: got %0d want 15 (16 cycles)", n); end
        checks++; if (data0 !== 9'd16) begin errors++; $display("FAIL ones_data2: got %0d want 16", data0); end
        idle_gap();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ones_idle: got %b want 0", busy0); end
    endtask

    task automatic test_zeros();
        int n;
        bit_in = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        wait_valid0(n);
        checks++; if (n !== 17 || data0 !== 9'd0) begin errors++; $display("FAIL zeros_first: got n=%0d d=%0d want 17/0", n, data0); end
        tick();
        wait_valid0(n);
        checks++; if (data0 !== 9'd0) begin errors++; $display("FAIL zeros_second: got %0d want 0", data0); end
        idle_gap();
    endtask

    task automatic test_toggle();
        int n;
        toggle = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        wait_valid0(n);
        checks++; if (data0 !== 9'd8) begin errors++; $display("FAIL toggle_first: got %0d want 8", data0); end
        tick();
        wait_valid0(n);
        checks++; if (data0 !== 9'd8) begin errors++; $display("FAIL toggle_second: got %0d want 8", data0); end
        idle_gap();
    endtask

    task automatic test_settle();
        int n;
        bit_in = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        n = 0;
        while (!valid1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n !== 49) begin errors++; $display("FAIL settle_latency: got %0d edges want 49", n); end
        checks++; if (data1 !== 9'd16) begin errors++; $display("FAIL settle_data: got %0d want 16", data1); end
        idle_gap();
    endtask

    task automatic test_overrun();
        int n;
        bit_in = 1'b1; out_ready = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        wait_valid0(n);
        // Second window sees only 2 ones, so an overwrite would be visible
        bit_in = 1'b0;
        checks++; if (n !== 17 || data0 !== 9'd16) begin errors++; $display("FAIL ovr_first: got n=%0d d=%0d want 17/16", n, data0); end
        repeat (15) tick();
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ovr0); end
        tick();
        checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovr0); end
        checks++; if (valid0 !== 1'b1 || data0 !== 9'd16) begin errors++; $display("FAIL ovr_held: got v%b d%0d want 1/16", valid0, data0); end
        tick();
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", ovr0); end
        repeat (13) tick();
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", ovr0); end
        checks++; if (data0 !== 9'd16) begin errors++; $display("FAIL ovr_held2: got %0d want 16", data0); end
        out_ready = 1'b1;
        tick();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b want 0", valid0); end
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_clear2: got %b want 0", ovr0); end
        idle_gap();
    endtask

    task automatic test_enable_drop();
        int n;
        bit_in = 1'b1; out_ready = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        wait_valid0(n);
        repeat (7) tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL drop_busy_before: got %b want 1", busy0); end
        enable = 1'b0;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL drop_busy_after: got %b want 0", busy0); end
        repeat (20) tick();
        checks++; if (valid0 !== 1'b1 || data0 !== 9'd16) begin errors++; $display("FAIL drop_pending: got v%b d%0d want 1/16", valid0, data0); end
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL drop_no_partial: got %b want 0", ovr0); end
        out_ready = 1'b1;
        tick();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL drop_consumed: got %b want 0", valid0); end
        idle_gap();
    endtask

    task automatic test_reset_mid();
        int n;
        bit_in = 1'b1; out_ready = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        wait_valid0(n);
        repeat (16) tick();
        checks++; if (ovr0 !== 1'b1 || valid0 !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got o%b v%b want 1/1", ovr0, valid0); end
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++; if (valid0 !== 1'b0 || data0 !== 9'd0) begin errors++; $display("FAIL rstmid_out: got v%b d%0d want 0/0", valid0, data0); end
        checks++; if (ovr0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got o%b b%b want 0/0", ovr0, busy0); end
        tick();
        rst = 1'b0;
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_ones();
        test_zeros();
        test_toggle();
        test_settle();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
